// File: rtl/ahb2apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb2apb_pkg
//  Description : Shared types and widths for the AHB-to-APB bridge halves.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb2apb_pkg;

  localparam int PKG_AW = 32;
  localparam int PKG_DW = 32;
  localparam int CMD_W  = 1 + PKG_AW + PKG_DW;
  localparam int RSP_W  = 1 + PKG_DW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic              write;
    logic [PKG_AW-1:0] addr;
    logic [PKG_DW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic              slverr;
    logic [PKG_DW-1:0] rdata;
  } rsp_t;

  // PSEL is asserted for both phases of an APB transfer.
  function automatic logic apb_phase_active(apb_state_e s);
    return (s == ST_SETUP) || (s == ST_ACCESS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb2apb_apb_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb2apb_apb_master_if
//  Description : FIFO-side and APB3 signal bundle of the bridge APB master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ahb2apb_apb_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cmd_rempty_i;
  logic [AW+DW:0] cmd_rdata_i;
  logic          cmd_rfifo_o;
  logic          rsp_wfull_i;
  logic          rsp_wfifo_o;
  logic [DW:0]   rsp_wdata_o;
  logic [AW-1:0] paddr_o;
  logic          pwrite_o;
  logic [DW-1:0] pwdata_o;
  logic          psel_o;
  logic          penable_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i;
  logic          pslverr_i;
  logic          busy_o;

  modport master (
    input  cmd_rempty_i, cmd_rdata_i, rsp_wfull_i, prdata_i, pready_i, pslverr_i,
    output cmd_rfifo_o, rsp_wfifo_o, rsp_wdata_o, paddr_o, pwrite_o, pwdata_o,
           psel_o, penable_o, busy_o
  );

  modport slave (
    output cmd_rempty_i, cmd_rdata_i, rsp_wfull_i, prdata_i, pready_i, pslverr_i,
    input  cmd_rfifo_o, rsp_wfifo_o, rsp_wdata_o, paddr_o, pwrite_o, pwdata_o,
           psel_o, penable_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/ahb2apb_apb_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : ahb2apb_apb_timeout
//  Description : Counts APB wait cycles; flags the cycle that reaches TO_CYC.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb2apb_apb_timeout #(
  parameter int TO_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  generate
    if (TO_CYC > 0) begin : g_timer
      localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (en_i) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Fires during the TO_CYC-th waiting cycle so ACCESS lasts exactly TO_CYC cycles.
      assign expired_o = en_i && (cnt_q == CW'(TO_CYC - 1));
    end else begin : g_no_timer
      logic unused_ok;
      assign unused_ok = clk ^ rst ^ en_i ^ clr_i;
      assign expired_o = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/ahb2apb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahb2apb_apb_master
//  Description : Pops bridge commands, runs one APB3 transfer each, pushes a response.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb2apb_apb_master
  import ahb2apb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  ahb2apb_apb_master_if.master bus
);

  apb_state_e    state_q, state_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [DW:0]   rsp_q, rsp_d;
  logic          cmd_take;
  logic          to_en;
  logic          to_clr;
  logic          to_expired;

  assign cmd_take = (state_q == ST_IDLE) && !bus.cmd_rempty_i;

  // Only wait cycles count; a same-cycle PREADY therefore always wins over the timeout.
  assign to_en  = (state_q == ST_ACCESS) && !bus.pready_i;
  assign to_clr = (state_d != ST_ACCESS);

  ahb2apb_apb_timeout #(
    .TO_CYC (TO_CYC)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .en_i      (to_en),
    .clr_i     (to_clr),
    .expired_o (to_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!bus.cmd_rempty_i) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (bus.pready_i || to_expired) state_d = ST_RESP;
      ST_RESP:   if (!bus.rsp_wfull_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rsp_d    = rsp_q;
    if (cmd_take) begin
      {pwrite_d, paddr_d, pwdata_d} = bus.cmd_rdata_i;
    end
    if (state_q == ST_ACCESS) begin
      if (bus.pready_i) begin
        rsp_d = {bus.pslverr_i, (pwrite_q ? {DW{1'b0}} : bus.prdata_i)};
      end else if (to_expired) begin
        rsp_d = {1'b1, {DW{1'b0}}};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rsp_q    <= '0;
    end else begin
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rsp_q    <= rsp_d;
    end
  end

  // The pop is gated by rst so nothing leaves the FIFO while reset is held.
  always_comb begin
    bus.cmd_rfifo_o = cmd_take && !rst;
    bus.psel_o      = apb_phase_active(state_q);
    bus.penable_o   = (state_q == ST_ACCESS);
    bus.rsp_wfifo_o = (state_q == ST_RESP) && !bus.rsp_wfull_i;
    bus.busy_o      = (state_q != ST_IDLE);
    bus.paddr_o     = paddr_q;
    bus.pwrite_o    = pwrite_q;
    bus.pwdata_o    = pwdata_q;
    bus.rsp_wdata_o = rsp_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb2apb_apb_master
//  Description : Scoreboard bench for the bridge APB master (TO_CYC = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb2apb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            waits;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb2apb_apb_master_if #(.AW(AW), .DW(DW)) bus ();

  ahb2apb_apb_master #(.AW(AW), .DW(DW), .TO_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  txn_t        cmd_q[$];
  txn_t        fly_q[$];
  logic [DW:0] exp_q[$];
  int          pop_log[$];
  int n_chk = 0, n_fail = 0, n_push = 0;
  int cyc = 0, full_pct = 0, force_full = 0;
  int acc_cnt = 0, setup_cnt = 0, stall_cnt = 0, fly_cyc = 0;
  int last_lat = 0, last_acc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: a transfer waiting TO or more cycles is cut off with {1, 0}.
  function automatic logic [DW:0] model_rsp(input txn_t t);
    if (TO > 0 && t.waits >= TO) return {1'b1, {DW{1'b0}}};
    return {t.err, (t.w ? {DW{1'b0}} : t.rdata)};
  endfunction

  function automatic int model_acc(input txn_t t);
    return (TO > 0 && t.waits >= TO) ? TO : t.waits + 1;
  endfunction

  task automatic add(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] rd, input logic e, input int wt);
    txn_t t;
    t.w = w; t.addr = a; t.wdata = d; t.rdata = rd; t.err = e; t.waits = wt;
    cmd_q.push_back(t);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #4;
      if (cmd_q.size() == 0 && fly_q.size() == 0 && !bus.busy_o) return;
    end
    chk("idle_timeout", 64'(cmd_q.size() + fly_q.size()) + 64'(bus.busy_o), 0);
  endtask

  // Command FIFO + APB slave model; inputs change on negedge, outputs sampled 1 before posedge.
  initial begin : bus_model
    txn_t t;
    bus.cmd_rempty_i = 1'b1;
    bus.cmd_rdata_i  = '0;
    bus.rsp_wfull_i  = 1'b0;
    bus.pready_i     = 1'b0;
    bus.pslverr_i    = 1'b0;
    bus.prdata_i     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cmd_q.size() > 0) begin
        bus.cmd_rempty_i = 1'b0;
        bus.cmd_rdata_i  = {cmd_q[0].w, cmd_q[0].addr, cmd_q[0].wdata};
      end else begin
        bus.cmd_rempty_i = 1'b1;
        bus.cmd_rdata_i  = {1'b1, $urandom, $urandom};
      end
      if (force_full > 0) begin
        bus.rsp_wfull_i = 1'b1;
        force_full--;
      end else begin
        bus.rsp_wfull_i = (int'($urandom_range(0, 99)) < full_pct);
      end
      if (bus.psel_o && bus.penable_o && fly_q.size() > 0) begin
        acc_cnt++;
        chk("apb_paddr", bus.paddr_o, fly_q[0].addr);
        chk("apb_pwrite", bus.pwrite_o, fly_q[0].w);
        chk("apb_pwdata", bus.pwdata_o, fly_q[0].wdata);
        if (acc_cnt - 1 == fly_q[0].waits) begin
          bus.pready_i  = 1'b1;
          bus.pslverr_i = fly_q[0].err;
          bus.prdata_i  = fly_q[0].rdata;
        end else begin
          bus.pready_i  = 1'b0;
          bus.pslverr_i = 1'($urandom);
          bus.prdata_i  = $urandom;
        end
      end else begin
        bus.pready_i  = 1'($urandom);
        bus.pslverr_i = 1'($urandom);
        bus.prdata_i  = $urandom;
      end
      #4;
      if (!rst) begin
        chk("penable_without_psel", {63'd0, bus.penable_o & ~bus.psel_o}, 0);
        if (bus.cmd_rfifo_o) begin
          chk("pop_when_busy", bus.busy_o, 0);
          chk("pop_when_empty", bus.cmd_rempty_i, 0);
          chk("pop_overlap", fly_q.size(), 0);
          if (cmd_q.size() > 0) begin
            t = cmd_q.pop_front();
            fly_q.push_back(t);
            exp_q.push_back(model_rsp(t));
            pop_log.push_back(cyc);
            fly_cyc = cyc; acc_cnt = 0; setup_cnt = 0; stall_cnt = 0;
          end
        end
        if (bus.psel_o && !bus.penable_o) setup_cnt++;
        if (bus.busy_o && !bus.psel_o && bus.rsp_wfull_i) stall_cnt++;
        if (bus.rsp_wfifo_o) begin
          chk("push_while_full", bus.rsp_wfull_i, 0);
          if (fly_q.size() > 0) begin
            t = fly_q.pop_front();
            last_acc = acc_cnt;
            last_lat = cyc - fly_cyc;
            chk("access_cycles", acc_cnt, model_acc(t));
            chk("setup_cycles", setup_cnt, 1);
            chk("push_latency", last_lat, 2 + model_acc(t) + stall_cnt);
          end
        end
      end
    end
  end

  // Response monitor: every push is compared against the scoreboard head.
  initial begin : rsp_monitor
    forever begin
      @(negedge clk); #4;
      if (!rst) begin
        if (bus.busy_o && !bus.psel_o) begin
          if (exp_q.size() > 0) chk("resp_data_hold", bus.rsp_wdata_o, exp_q[0]);
          chk("resp_push", bus.rsp_wfifo_o, !bus.rsp_wfull_i);
          chk("resp_no_pop", bus.cmd_rfifo_o, 0);
        end
        if (bus.rsp_wfifo_o) begin
          n_push++;
          if (exp_q.size() == 0) chk("unexpected_push", bus.rsp_wfifo_o, 0);
          else chk("rsp_wdata", bus.rsp_wdata_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int wsel[8];
    int base;
    wsel = '{0, 0, 1, 2, 3, 7, 8, 11};

    // Write queued while reset is held: no pop until reset is gone.
    add(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 1'b0, 0);
    repeat (3) @(negedge clk);
    #2;
    chk("rst_psel", bus.psel_o, 0);
    chk("rst_penable", bus.penable_o, 0);
    chk("rst_cmd_rfifo", bus.cmd_rfifo_o, 0);
    chk("rst_rsp_wfifo", bus.rsp_wfifo_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_paddr", bus.paddr_o, 0);
    chk("rst_pwdata", bus.pwdata_o, 0);
    chk("rst_pwrite", bus.pwrite_o, 0);
    chk("rst_rsp_wdata", bus.rsp_wdata_o, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_idle();
    chk("write_latency", last_lat, 3);
    chk("write_access_cycles", last_acc, 1);

    add(1'b0, 32'h0000_2000, 32'h0, 32'h1234_5678, 1'b0, 3);
    wait_idle();
    chk("read_wait_penable_cycles", last_acc, 4);

    add(1'b0, 32'h0000_3000, 32'h0, 32'hCAFE_0001, 1'b1, 1);
    add(1'b0, 32'h0000_3004, 32'h0, 32'hCAFE_0002, 1'b0, 20);
    wait_idle();
    chk("timeout_access_cycles", last_acc, TO);
    add(1'b0, 32'h0000_3008, 32'h0, 32'hCAFE_0003, 1'b1, TO - 1);
    add(1'b1, 32'h0000_300C, 32'h1111_2222, 32'hCAFE_0004, 1'b0, TO);
    wait_idle();

    // Response FIFO full for 5 cycles from the first RESP cycle.
    add(1'b0, 32'h0000_4000, 32'h0, 32'h0BAD_F00D, 1'b0, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #4;
      if (bus.penable_o && bus.pready_i) break;
    end
    force_full = 5;
    wait_idle();
    chk("stall_latency", last_lat, 8);

    pop_log.delete();
    for (int i = 0; i < 4; i++)
      add(i[0], 32'h0000_5000 + 32'(i * 4), $urandom, $urandom, 1'b0, 0);
    wait_idle();
    chk("b2b_pop_count", pop_log.size(), 4);
    for (int i = 1; i < 4 && i < pop_log.size(); i++)
      chk("b2b_pop_spacing", pop_log[i] - pop_log[i-1], 4);

    // Reset during ACCESS aborts the first read; the second runs normally.
    base = n_push;
    add(1'b0, 32'h0000_6000, 32'h0, 32'h6666_0000, 1'b0, 5);
    add(1'b0, 32'h0000_6004, 32'h0, 32'h6666_0004, 1'b0, 5);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #4;
      if (bus.penable_o) break;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("abort_psel", bus.psel_o, 0);
    chk("abort_penable", bus.penable_o, 0);
    chk("abort_busy", bus.busy_o, 0);
    fly_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle();
    chk("abort_push_count", n_push - base, 1);

    full_pct = 30;
    for (int i = 0; i < 40; i++) begin
      add(1'($urandom), $urandom, $urandom, $urandom, 1'($urandom_range(0, 3) == 0),
          wsel[$urandom_range(0, 7)]);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    wait_idle();
    full_pct = 0;
    repeat (3) @(negedge clk);

    chk("drain_cmd_q", cmd_q.size(), 0);
    chk("drain_exp_q", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb2apb_apb_master.md
AHB2APB_APB_MASTER -- requirements
Module: ahb2apb_apb_master

Interface
REQ-001 SHALL have parameter AW, default 32: APB address width.
REQ-002 SHALL have parameter DW, default 32: APB data width.
REQ-003 SHALL have parameter TO_CYC, default 256: PREADY timeout in cycles; 0 disables timeout.
REQ-004 SHALL have port clk, input, 1: APB-domain clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port cmd_rempty_i, input, 1: command FIFO empty flag from the read-side controller.
REQ-007 SHALL have port cmd_rdata_i, input, 1+AW+DW: FIFO head {write, addr, wdata}; valid whenever cmd_rempty_i=0.
REQ-008 SHALL have port cmd_rfifo_o, output, 1: pop request to the command FIFO read controller.
REQ-009 SHALL have port rsp_wfull_i, input, 1: response FIFO full flag.
REQ-010 SHALL have port rsp_wfifo_o, output, 1: push request to the response FIFO write controller.
REQ-011 SHALL have port rsp_wdata_o, output, 1+DW: response {slverr, rdata}.
REQ-012 SHALL have ports paddr_o (AW), pwrite_o (1), pwdata_o (DW), psel_o (1) and penable_o (1) as outputs: APB3 request.
REQ-013 SHALL have ports prdata_i (DW), pready_i (1) and pslverr_i (1) as inputs: APB3 completion.
REQ-014 SHALL have port busy_o, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-016 In IDLE with cmd_rempty_i=0, the block SHALL assert cmd_rfifo_o combinationally for exactly one cycle, register cmd_rdata_i into paddr_o/pwrite_o/pwdata_o, and go to SETUP.
REQ-017 cmd_rfifo_o SHALL be 0 in every state other than IDLE and whenever cmd_rempty_i=1.
REQ-018 SETUP SHALL drive psel_o=1 and penable_o=0 for one cycle, then go to ACCESS unconditionally.
REQ-019 ACCESS SHALL drive psel_o=1 and penable_o=1; paddr_o, pwrite_o and pwdata_o SHALL be held stable from SETUP through the end of ACCESS.
REQ-020 On pready_i=1 in ACCESS, the block SHALL capture {pslverr_i, prdata_i} into rsp_wdata_o, deassert psel_o and penable_o next cycle, and go to RESP.
REQ-021 For writes, rdata in the captured response SHALL be zero.
REQ-022 Timeout: when TO_CYC>0, a counter SHALL count ACCESS cycles with pready_i=0.
REQ-023 When that counter reaches TO_CYC, the block SHALL end the transfer, capture {1'b1, 0}, and go to RESP; the counter SHALL clear on leaving ACCESS.
REQ-024 In RESP with rsp_wfull_i=0, the block SHALL assert rsp_wfifo_o for exactly one cycle and go to IDLE.
REQ-025 In RESP with rsp_wfull_i=1, the block SHALL hold RESP, rsp_wfifo_o=0 and rsp_wdata_o stable, with no APB activity.
REQ-026 Every popped command SHALL produce exactly one response push, in command order.
REQ-027 Latency: pop at cycle T, SETUP T+1, ACCESS T+2; with pready at T+2, push at T+3 and IDLE at T+4, giving 4 cycles per transfer back-to-back with zero wait states.
REQ-028 Zero-wait back-to-back: psel_o SHALL drop for at least one cycle (RESP and IDLE) between transfers.
REQ-029 pready_i and pslverr_i SHALL be ignored outside ACCESS.
REQ-030 Timeout and pready_i=1 in the same cycle SHALL resolve as a normal pready completion.

Reset
REQ-031 On rst=1, the block SHALL go to IDLE immediately and drive psel_o, penable_o, cmd_rfifo_o, rsp_wfifo_o and busy_o to 0.
REQ-032 On rst=1, paddr_o, pwdata_o, pwrite_o, rsp_wdata_o and the timeout counter SHALL all be 0.
REQ-033 Reset mid-transfer SHALL abort the APB cycle; the popped command is discarded and no response is pushed.
REQ-034 The first pop after rst deasserts SHALL occur no earlier than the first rising clk edge with rst=0.

Structure
REQ-035 Package ahb2apb_pkg SHALL hold the FSM state enum, the CMD_W=1+AW+DW and RSP_W=1+DW constants, and the packed cmd/rsp structs, shared with the AHB-side bridge.
REQ-036 Sub-module ahb2apb_apb_timeout SHALL contain the timeout counter (inputs: enable, clear; output: expired); the FSM SHALL stay in this module.

Verification
REQ-037 Write 0x0000_1004/0xDEAD_BEEF, pready=1 immediately -> one APB write with psel_o high 2 cycles; response {0, 0x0} pushed at T+3.
REQ-038 Read 0x0000_2000, pready low 3 cycles, prdata=0x1234_5678 -> penable_o high 4 cycles; response {0, 0x1234_5678}.
REQ-039 Read, pslverr=1 with pready, TO_CYC=8, pready stuck low -> first response {1, data}; stuck case ends after 8 ACCESS cycles with push {1, 0}.
REQ-040 rsp_wfull_i=1 for 5 cycles at RESP -> no push or new pop during the stall; push on the first cycle full=0.
REQ-041 4 queued commands, zero wait -> pops at T, T+4, T+8, T+12; 4 in-order responses.
REQ-042 rst pulsed during ACCESS -> psel_o/penable_o=0 same cycle, no push; next queued command executes normally after release.
